icache_memctrl: RTL

- Memory-side stage directly downstream of the direct-mapped instruction cache controller. It serves the cache's line-refill requests (memory_stb/memory_addr/memory_data/memory_ack).
- Each 32-bit word request becomes two consecutive reads of a 16-bit asynchronous SRAM, each with a programmable number of wait states.
- The block assembles the two halves and returns the word with a single-cycle ack.
- Read-only; instruction path only.

---
 rtl/icache_memctrl_if.sv | 27 ++
 rtl/icache_memctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/icache_memctrl_if.sv
// icache_memctrl_if: refill bus between the instruction cache controller and its
// memory-side stage.
//   memory_stb  - refill request, held high by the cache until ack
//   memory_addr - 14-bit word address {tag,index}
//   memory_data - assembled 32-bit word, valid in the ack cycle
//   memory_ack  - single-cycle completion pulse
// Modports: master = cache side, slave = memory controller side.
interface icache_memctrl_if;
  logic        memory_stb;
  logic [13:0] memory_addr;
  logic [31:0] memory_data;
  logic        memory_ack;

  modport master (
    output memory_stb,
    output memory_addr,
    input  memory_data,
    input  memory_ack
  );

  modport slave (
    input  memory_stb,
    input  memory_addr,
    output memory_data,
    output memory_ack
  );
endinterface

// File: rtl/icache_memctrl.sv
// icache_memctrl: serves instruction-cache line refills from a 16-bit asynchronous
// SRAM. Each 32-bit word is read as two halfwords (even address -> bits 31:16,
// odd address -> bits 15:0), each phase lasting WAIT_STATES+1 cycles, then
// returned with a single-cycle ack. Read-only.
// Ports:
//   clk, rst  - clock (rising edge) and synchronous active-high reset
//   mem_bus   - refill bus (slave side): memory_stb/addr in, memory_data/ack out
//   sram_addr - SRAM halfword address
//   sram_ce_n - SRAM chip enable, active low
//   sram_oe_n - SRAM output enable, active low
//   sram_data - SRAM read data
// All outputs are registered.
module icache_memctrl #(
  parameter int unsigned WAIT_STATES = 2  // legal 0..15
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_memctrl_if.slave        mem_bus,
  output logic [14:0]            sram_addr,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  input  logic [15:0]            sram_data
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StRdHi, StRdLo, StAck} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] addr_buf_q, addr_buf_d;
  logic [31:0] data_q, data_d;
  logic        ack_q, ack_d;
  logic [14:0] sram_addr_q, sram_addr_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_buf_q  <= 14'd0;
      data_q      <= 32'd0;
      ack_q       <= 1'b0;
      sram_addr_q <= 15'd0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_buf_q  <= addr_buf_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_buf_d  = addr_buf_q;
    data_d      = data_q;
    ack_d       = 1'b0;
    sram_addr_d = sram_addr_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;

    unique case (state_q)
      StIdle: begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        if (mem_bus.memory_stb) begin
          addr_buf_d  = mem_bus.memory_addr;
          sram_addr_d = {mem_bus.memory_addr, 1'b0};
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b0;
          cnt_d       = WaitLoad;
          state_d     = StRdHi;
        end
      end
      StRdHi: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Big-endian: even halfword lands in the upper half of the word.
          data_d[31:16] = sram_data;
          sram_addr_d   = {addr_buf_q, 1'b1};
          cnt_d         = WaitLoad;
          state_d       = StRdLo;
        end
      end
      StRdLo: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d[15:0] = sram_data;
          ce_n_d       = 1'b1;
          oe_n_d       = 1'b1;
          ack_d        = 1'b1;
          state_d      = StAck;
        end
      end
      StAck: begin
        // Request line is not looked at here; the cache drops it after ack.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_bus.memory_data = data_q;
  assign mem_bus.memory_ack  = ack_q;
  assign sram_addr           = sram_addr_q;
  assign sram_ce_n           = ce_n_q;
  assign sram_oe_n           = oe_n_q;

endmodule
